// File: rtl/config_pkg.sv
// config_pkg: core configuration record shared by the CVA6 blocks
//   cva6_cfg_t     : configuration fields consumed by this slice
//   cva6_cfg_empty : default configuration (two commit ports)
package config_pkg;
  typedef struct packed {
    int unsigned NrCommitPorts;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 2};
endpackage

// File: rtl/regfile_wb_serializer_pkg.sv
// regfile_wb_serializer_pkg: constants shared by the write-back serializer
//   REG_ADDR_W : architectural register address width
package regfile_wb_serializer_pkg;
  localparam int unsigned REG_ADDR_W = 5;
endpackage

// File: rtl/regfile_wb_serializer.sv
// regfile_wb_serializer: queues multi-port commit writes and drains them one per cycle into a single-write-port register file
//   clk_i, rst_ni                 : clock, async active-low reset
//   we_i, waddr_i, wdata_i        : commit write group (lower port index is older)
//   ready_o                       : a full commit group fits this cycle
//   rf_we_o, rf_waddr_o, rf_wdata_o : register-file write port (head of queue)
//   raddr_i, fwd_hit_o, fwd_data_o  : operand lookups forwarded from pending writes
//   idle_o                        : no write pending
module regfile_wb_serializer
  import regfile_wb_serializer_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NR_READ_PORTS = 2,
  parameter int unsigned DEPTH = 4,
  parameter bit ZERO_REG_ZERO = 1'b0
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_ni,
  input  logic [CVA6Cfg.NrCommitPorts-1:0]                       we_i,
  input  logic [CVA6Cfg.NrCommitPorts-1:0][REG_ADDR_W-1:0]       waddr_i,
  input  logic [CVA6Cfg.NrCommitPorts-1:0][DATA_WIDTH-1:0]       wdata_i,
  output logic                                                   ready_o,
  output logic                                                   rf_we_o,
  output logic [REG_ADDR_W-1:0]                                  rf_waddr_o,
  output logic [DATA_WIDTH-1:0]                                  rf_wdata_o,
  input  logic [NR_READ_PORTS-1:0][REG_ADDR_W-1:0]               raddr_i,
  output logic [NR_READ_PORTS-1:0]                               fwd_hit_o,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]               fwd_data_o,
  output logic                                                   idle_o
);
  localparam int unsigned NCP = CVA6Cfg.NrCommitPorts;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0] count_q, count_d, n_push;
  logic [NCP-1:0] keep;
  logic push, pop;
  entry_t head;
  for (genvar p = 0; p < NCP; p++) begin : g_keep
    assign keep[p] = we_i[p] && !(ZERO_REG_ZERO && waddr_i[p] == '0);
  end
  // Acceptance depends on the current fill only, so commit sees no path through the drain.
  assign ready_o = ((PW+1)'(DEPTH) - count_q) >= (PW+1)'(NCP);
  assign push = ready_o && |keep;
  assign pop = count_q != '0;
  assign head = mem_q[rd_ptr_q];
  assign rf_we_o = pop;
  assign rf_waddr_o = pop ? head.addr : '0;
  assign rf_wdata_o = pop ? head.data : '0;
  assign idle_o = !pop;
  // Kept ports are packed into consecutive slots in port order; the popped head
  // can never collide with a written slot because ready_o guarantees free room.
  always_comb begin
    mem_d = mem_q;
    n_push = '0;
    if (pop) mem_d[rd_ptr_q].valid = 1'b0;
    for (int unsigned p = 0; p < NCP; p++) begin
      if (push && keep[p]) begin
        mem_d[wr_ptr_q + PW'(n_push)] = '{valid: 1'b1, addr: waddr_i[p], data: wdata_i[p]};
        n_push = n_push + (PW+1)'(1);
      end
    end
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(n_push);
    count_d = count_q + n_push - (PW+1)'(pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
  // Scan from oldest (head) to youngest so the last match found is the youngest.
  always_comb begin
    fwd_hit_o = '0;
    fwd_data_o = '0;
    for (int unsigned k = 0; k < NR_READ_PORTS; k++) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        if (mem_q[rd_ptr_q + PW'(a)].valid && mem_q[rd_ptr_q + PW'(a)].addr == raddr_i[k] &&
            !(ZERO_REG_ZERO && raddr_i[k] == '0)) begin
          fwd_hit_o[k] = 1'b1;
          fwd_data_o[k] = mem_q[rd_ptr_q + PW'(a)].data;
        end
      end
    end
  end
  a_no_write_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(|we_i) || ready_o);
endmodule

// File: tb/tb_regfile_wb_serializer.sv
// tb_regfile_wb_serializer: scoreboard bench for the write-back serializer (2 commit ports, depth 4, x0 discarded)
module tb_regfile_wb_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] we;
  logic [1:0][4:0] waddr;
  logic [1:0][31:0] wdata;
  logic ready, rf_we, idle;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0][4:0] raddr;
  logic [1:0] fwd_hit;
  logic [1:0][31:0] fwd_data;
  int checks = 0;
  int errors = 0;
  bit saw_not_ready = 0;
  logic [36:0] sb[$];
  logic [36:0] exp_e;

  regfile_wb_serializer #(
    .CVA6Cfg(config_pkg::cva6_cfg_empty),
    .DATA_WIDTH(32),
    .NR_READ_PORTS(2),
    .DEPTH(4),
    .ZERO_REG_ZERO(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .we_i(we),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .ready_o(ready),
    .rf_we_o(rf_we),
    .rf_waddr_o(rf_waddr),
    .rf_wdata_o(rf_wdata),
    .raddr_i(raddr),
    .fwd_hit_o(fwd_hit),
    .fwd_data_o(fwd_data),
    .idle_o(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rf_extra got x%0d=%0h want none", rf_waddr, rf_wdata);
      end else begin
        exp_e = sb.pop_front();
        if ({rf_waddr, rf_wdata} !== exp_e) begin
          errors++;
          $display("FAIL rf_write got x%0d=%0h want x%0d=%0h", rf_waddr, rf_wdata, exp_e[36:32], exp_e[31:0]);
        end
      end
    end
  end

  // Called at a negedge; waits for room, presents the group, returns at the negedge after acceptance.
  task automatic issue(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    int t = 0;
    while (!ready && t < 20) begin
      saw_not_ready = 1;
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 64'(ready), 64'd1);
    we = w;
    waddr[0] = a0;
    wdata[0] = d0;
    waddr[1] = a1;
    wdata[1] = d1;
    if (w[0] && a0 != 0) sb.push_back({a0, d0});
    if (w[1] && a1 != 0) sb.push_back({a1, d1});
    @(posedge clk);
    #1 we = 2'b00;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!idle && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", 64'(idle), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    chk({tag, "_rf_we"}, 64'(rf_we), 64'd0);
    chk({tag, "_rf_waddr"}, 64'(rf_waddr), 64'd0);
    chk({tag, "_rf_wdata"}, 64'(rf_wdata), 64'd0);
    chk({tag, "_fwd_hit"}, 64'(fwd_hit), 64'd0);
    chk({tag, "_fwd_data"}, 64'(fwd_data), 64'd0);
    chk({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    we = '0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    // two writes to x5 in one group: youngest forwards, both drain in order
    raddr[0] = 5'd5;
    raddr[1] = 5'd6;
    issue(2'b11, 5'd5, 32'hA, 5'd5, 32'hB);
    chk("dup_hit", 64'(fwd_hit[0]), 64'd1);
    chk("dup_data", 64'(fwd_data[0]), 64'hB);
    chk("dup_miss_hit", 64'(fwd_hit[1]), 64'd0);
    chk("dup_miss_data", 64'(fwd_data[1]), 64'd0);
    chk("dup_head_addr", 64'(rf_waddr), 64'd5);
    chk("dup_head_data", 64'(rf_wdata), 64'hA);
    @(negedge clk);
    chk("dup_second_data", 64'(rf_wdata), 64'hB);
    chk("dup_second_hit", 64'(fwd_data[0]), 64'hB);
    @(negedge clk);
    chk("dup_drained_idle", 64'(idle), 64'd1);
    chk("dup_drained_hit", 64'(fwd_hit[0]), 64'd0);
    chk("dup_drained_data", 64'(fwd_data[0]), 64'd0);
    // x9 forwarded while it is the head being drained, gone the cycle after
    raddr[0] = 5'd9;
    issue(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
    chk("head_rf_we", 64'(rf_we), 64'd1);
    chk("head_hit", 64'(fwd_hit[0]), 64'd1);
    chk("head_data", 64'(fwd_data[0]), 64'h99);
    chk("head_not_idle", 64'(idle), 64'd0);
    @(negedge clk);
    chk("head_after_hit", 64'(fwd_hit[0]), 64'd0);
    chk("head_after_idle", 64'(idle), 64'd1);
    // x0 write is discarded and x0 lookups miss
    raddr[0] = 5'd0;
    raddr[1] = 5'd7;
    issue(2'b11, 5'd0, 32'h1, 5'd7, 32'h2);
    chk("zero_hit", 64'(fwd_hit[0]), 64'd0);
    chk("zero_data", 64'(fwd_data[0]), 64'd0);
    chk("x7_hit", 64'(fwd_hit[1]), 64'd1);
    chk("x7_data", 64'(fwd_data[1]), 64'd2);
    chk("x7_head", 64'(rf_waddr), 64'd7);
    @(negedge clk);
    chk("zero_single_entry_idle", 64'(idle), 64'd1);
    // enqueue 2 while draining 1 at count 2, then async reset with 3 entries pending
    raddr[0] = 5'd3;
    issue(2'b11, 5'd1, 32'h11, 5'd2, 32'h22);
    chk("cnt2_ready", 64'(ready), 64'd1);
    issue(2'b11, 5'd3, 32'h33, 5'd4, 32'h44);
    chk("cnt3_ready", 64'(ready), 64'd0);
    chk("cnt3_idle", 64'(idle), 64'd0);
    chk("cnt3_head", 64'(rf_waddr), 64'd2);
    chk("cnt3_fwd", 64'(fwd_data[0]), 64'h33);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'(idle), 64'd1);
    // sustained 2-wide commit across several pointer wraps
    saw_not_ready = 0;
    for (int i = 0; i < 8; i++)
      issue(2'b11, 5'(8 + i), 32'h1000 + 32'(i), 5'(16 + i), 32'h2000 + 32'(i));
    chk("stream_ready_dropped", 64'(saw_not_ready), 64'd1);
    wait_idle();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_serializer.md
# regfile_wb_serializer

Write-side front end for a single-write-port FPGA register file. It accepts up to NrCommitPorts architectural register writes per cycle from commit and buffers them in order in a small circular queue. It drains the queue to the register file at one write per cycle. While writes are pending, it forwards their data to the operand-read ports so readers never see stale register values. It sits between commit and the register file.

## Interface
- CVA6Cfg, config_pkg::cva6_cfg_empty: provides NrCommitPorts.
- DATA_WIDTH, 32: register width.
- NR_READ_PORTS, 2: number of forwarding lookup ports.
- DEPTH, 4: queue entries. Must be a power of two and at least NrCommitPorts.
- ZERO_REG_ZERO, 0: when 1, writes to address 0 are discarded at enqueue.

Ports:
- clk_i in 1: clock.
- rst_ni in 1: asynchronous reset, active low.
- we_i in [NrCommitPorts]: commit write requests.
- waddr_i in [NrCommitPorts][5]: destination addresses.
- wdata_i in [NrCommitPorts][DATA_WIDTH]: write data.
- ready_o out 1: the queue can accept a full commit group this cycle.
- rf_we_o out 1: register-file write enable.
- rf_waddr_o out 5: register-file write address.
- rf_wdata_o out DATA_WIDTH: register-file write data.
- raddr_i in [NR_READ_PORTS][5]: lookup addresses.
- fwd_hit_o out [NR_READ_PORTS]: a pending write matches the lookup address.
- fwd_data_o out [NR_READ_PORTS][DATA_WIDTH]: data of the youngest matching pending write.
- idle_o out 1: the queue is empty.

## Operation
- State: entries {valid, addr, data}; rd_ptr and wr_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH; count, log2(DEPTH)+1 bits.
- Accept:
  - The enqueue condition is ready_o and any we_i.
  - ready_o = (DEPTH - count) >= NrCommitPorts. It uses the current count only and never depends on the same-cycle dequeue.
  - Commit must hold its requests while ready_o is 0.
  - Behaviour when we_i is asserted while ready_o is 0 is undefined; an assertion flags it.
- Enqueue order:
  - Active ports are compacted in ascending port index. A lower index is older.
  - Entries are written at wr_ptr, wr_ptr+1, and so on.
  - wr_ptr advances by the number of accepted writes, which is popcount of the kept we_i.
  - With ZERO_REG_ZERO=1, a port with waddr_i==0 is masked out before compaction and consumes no entry.
- Drain:
  - rf_we_o = (count != 0). rf_waddr_o and rf_wdata_o equal the head entry.
  - When rf_we_o is high, the entry pops at the next edge and rd_ptr increments.
  - The register file always accepts, so no back-pressure is needed.
- Simultaneous enqueue and dequeue: count_next = count + pushed - popped.
- Forwarding, evaluated per read port k:
  - Search all valid entries, including the head being drained this cycle.
  - Youngest match wins. Age is the distance from rd_ptr.
  - On a hit, fwd_hit_o[k]=1 and fwd_data_o[k] carries that entry's data.
  - On a miss, fwd_hit_o[k]=0 and fwd_data_o[k]=0.
  - With ZERO_REG_ZERO=1, lookups of address 0 always miss.
  - Writes presented on we_i in the same cycle are not forwarded.
- Duplicate addresses in the queue are legal. Each is drained in order, so the last write lands last.
- idle_o = (count == 0). Fences use it to wait for write-back to finish.

## Timing
- Reset values: count=0, pointers=0, all valid=0, ready_o=1, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, fwd_hit_o=0, fwd_data_o=0, idle_o=1.
- Reset asserted mid-operation drops all pending writes immediately. This is asynchronous; no drain occurs.
- Latency:
  - A write accepted at edge N is visible on forwarding in cycle N+1.
  - It is at the head at the earliest in cycle N+1 and is committed to the register file at edge N+1 when the queue was empty.
- Throughput: enqueue up to NrCommitPorts per cycle, drain 1 per cycle. Sustained multi-port commit therefore fills the queue and deasserts ready_o.
- Full, count==DEPTH: ready_o=0 and draining continues.
- Empty: rf_we_o=0 and every lookup misses.
- All outputs are combinational from registered state. There is no combinational path from we_i to any output.

## Structure
- No new shared-package content. The entry struct is a local typedef parameterized by DATA_WIDTH.
- NrCommitPorts comes from CVA6Cfg, as in the rest of the core.
- No sub-module is needed. Compaction and youngest-match search are generate loops inside the block.

## Test plan
- Reset with the queue holding 3 entries: all outputs return to their reset values and idle_o=1.
- NrCommitPorts=2, writes {x5=0xA, x5=0xB} in one cycle, then a lookup of x5: hit with data 0xB. The register file then receives x5=0xA followed by x5=0xB on consecutive cycles.
- DEPTH=4, continuous 2-wide commits: ready_o deasserts when count reaches 3 or 4, no write is lost, and the rf write sequence matches the accept order across pointer wrap.
- Enqueue of 2 while draining 1 at count=2: count=3 on the next cycle and ready_o=0.
- ZERO_REG_ZERO=1, writes {x0=0x1, x7=0x2}: only x7 is enqueued, and a lookup of x0 misses.
- Lookup of x9 while x9 is at the head with rf_we_o=1: hit in that cycle, miss in the following cycle.
